stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
Parametrised, registered 1-to-N_CH stream demultiplexer with valid/ready handshakes on the input and on every output channel. Each output channel has its own one-entry output register, so a stalled channel blocks only beats aimed at it. It supports three routing modes: addressed, sequential scan and broadcast. It replaces the combinational 1-to-4 demux wherever traffic must be steered between back-pressured consumers.

Parameters:
WIDTH, 8, data bits per beat
N_CH, 4, number of output channels (2..16)
SEL_W, derived localparam = max(1, clog2(N_CH)), not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input beat payload
in_valid  input  1  input beat present
in_ready  output  1  block accepts the beat this cycle
in_sel  input  SEL_W  target channel (addressed mode only)
mode  input  2  0=addressed, 1=scan, 2=broadcast, 3=reserved
out_data  output  N_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
out_valid  output  N_CH  per-channel beat present
out_ready  input  N_CH  per-channel consumer ready
drop_err  output  1  one-cycle pulse: a beat was dropped on an invalid in_sel
scan_ptr  output  SEL_W  current scan-mode target channel

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, drop_err=0, scan_ptr=0, internal last_mode=0.
- Transfer rule: an input beat transfers when in_valid && in_ready. An output beat on channel c transfers when out_valid[c] && out_ready[c].
- free[c] = !out_valid[c] || out_ready[c]. This is combinational, so a full channel that is draining this cycle can accept a new beat (full throughput of 1 beat/cycle per channel).
- in_ready by mode:
  - addressed: free[in_sel] when in_sel < N_CH; 1 when in_sel >= N_CH.
  - scan: free[scan_ptr].
  - broadcast: AND of all free[c].
  - reserved: 0.
- in_ready depends combinationally on out_ready, mode, in_sel and scan_ptr. It never depends on in_valid.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k. Data is captured into the target register(s).
- Broadcast: a single accept loads every channel with in_data.
- Hold: while out_valid[c] && !out_ready[c], out_data[c] and out_valid[c] are held stable.
- Channel update each edge:
  - load on accept targeting c, else
  - clear out_valid[c] on output transfer, else
  - hold.
  - Simultaneous drain and load of the same channel: the load wins and out_valid stays 1.
- Invalid select: an addressed accept with in_sel >= N_CH loads nothing. drop_err=1 for exactly the next cycle, then 0.
- Scan pointer:
  - Increments by 1 on each scan-mode accept and wraps N_CH-1 -> 0 (no power-of-two assumption).
  - When mode differs from last_mode on an edge, scan_ptr is forced to 0 regardless of any accept. last_mode is registered each cycle.
- Mode and in_sel may change in any cycle. They are sampled only at the accept edge.
- Reset mid-operation: all pending output beats are discarded immediately and asynchronously. No partial broadcast survives.

Decomposition:
- Package stream_pkg holds:
  - mode encodings: MODE_ADDR=2'd0, MODE_SCAN=2'd1, MODE_BCAST=2'd2, MODE_RSVD=2'd3;
  - a clog2-based SEL_W helper function.
- Sub-module demux_out_reg (WIDTH): one channel register with load/valid/ready, instantiated N_CH times in a generate loop.
- Top level contains the ready/target decode, the scan pointer and drop_err.

Test Plan:
- Addressed, all out_ready=1, WIDTH=8, N_CH=4: beats 8'hA0..A3 with in_sel=0..3 on consecutive cycles -> each out_valid[c] pulses one cycle later with data A0+c; in_ready stays 1 throughout.
- Backpressure: out_ready[2]=0, send 8'h55 to ch2, then 8'h66 to ch2, then 8'h77 to ch1 -> ch2 holds 55; in_ready=0 while 66 is presented; raising out_ready[2] accepts 66 the same cycle; 77 reaches ch1 without waiting on ch2.
- Scan with N_CH=3 (wrap check), out_ready all 1: 5 beats 01..05 -> delivered to ch0, ch1, ch2, ch0, ch1; scan_ptr ends at 2. Switching mode to 0 and back to 1 -> scan_ptr=0.
- Broadcast: out_ready=4'b1011, beat 8'hC3 -> all four channels load C3. Next beat 8'hC4 is stalled (in_ready=0) until out_ready[2]=1; then all four channels load C4.
- Invalid select with N_CH=3: in_sel=3, in_valid=1 -> in_ready=1, no out_valid rises, drop_err=1 for exactly one cycle.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while ch1 holds an unaccepted beat -> out_valid=0, drop_err=0 and scan_ptr=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared mode encodings and select-width helper for stream_demux
package stream_pkg;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_BCAST = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  function automatic int calc_sel_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/demux_out_reg.sv
// rtl/demux_out_reg.sv - one-entry output register for a single demux channel
module demux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // A load in the same cycle as a drain wins, keeping valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demux with addressed, scan and broadcast routing
module stream_demux
  import stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_CH  = 4,
  localparam int SEL_W = calc_sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [1:0]            mode,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic                  drop_err,
  output logic [SEL_W-1:0]      scan_ptr
);

  localparam int               PAD_N   = 1 << SEL_W;
  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [N_CH-1:0]  free;
  logic [N_CH-1:0]  load;
  logic [PAD_N-1:0] free_pad;
  logic             sel_ok;
  logic             accept;
  logic [1:0]       last_mode;

  assign sel_ok = ({1'b0, in_sel} < N_CH_L);

  // Padding lets in_sel/scan_ptr index safely when N_CH is not a power of two.
  always_comb begin
    free     = ~out_valid | out_ready;
    free_pad = '0;
    free_pad[N_CH-1:0] = free;
    in_ready = 1'b0;
    load     = '0;
    case (mode)
      MODE_ADDR:  in_ready = sel_ok ? free_pad[in_sel] : 1'b1;
      MODE_SCAN:  in_ready = free_pad[scan_ptr];
      MODE_BCAST: in_ready = &free;
      default:    in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    for (int c = 0; c < N_CH; c++) begin
      case (mode)
        MODE_ADDR:  load[c] = accept && (in_sel == SEL_W'(c));
        MODE_SCAN:  load[c] = accept && (scan_ptr == SEL_W'(c));
        MODE_BCAST: load[c] = accept;
        default:    load[c] = 1'b0;
      endcase
    end
  end

  // A mode change resets the scan sequence even if a beat is accepted that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr  <= '0;
      last_mode <= MODE_ADDR;
      drop_err  <= 1'b0;
    end else begin
      last_mode <= mode;
      drop_err  <= accept && (mode == MODE_ADDR) && !sel_ok;
      if (mode != last_mode)
        scan_ptr <= '0;
      else if (accept && (mode == MODE_SCAN))
        scan_ptr <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    demux_out_reg #(.WIDTH(WIDTH)) u_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[c]),
      .load_data (in_data),
      .ready     (out_ready[c]),
      .data      (out_data[c*WIDTH +: WIDTH]),
      .valid     (out_valid[c])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed self-checking bench for stream_demux (N_CH=4 and N_CH=3)
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  in_data4;
  logic        in_valid4;
  logic        in_ready4;
  logic [1:0]  in_sel4;
  logic [1:0]  mode4;
  logic [31:0] out_data4;
  logic [3:0]  out_valid4;
  logic [3:0]  out_ready4;
  logic        drop_err4;
  logic [1:0]  scan_ptr4;

  logic [7:0]  in_data3;
  logic        in_valid3;
  logic        in_ready3;
  logic [1:0]  in_sel3;
  logic [1:0]  mode3;
  logic [23:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        drop_err3;
  logic [1:0]  scan_ptr3;

  stream_demux #(.WIDTH(8), .N_CH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .in_sel(in_sel4), .mode(mode4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .drop_err(drop_err4),
    .scan_ptr(scan_ptr4)
  );

  stream_demux #(.WIDTH(8), .N_CH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .in_sel(in_sel3), .mode(mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .drop_err(drop_err3),
    .scan_ptr(scan_ptr3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] scan_ch [5];
    scan_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    rst_n = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; in_sel4 = '0; mode4 = 2'd0; out_ready4 = 4'hF;
    in_data3 = '0; in_valid3 = 1'b0; in_sel3 = '0; mode3 = 2'd0; out_ready3 = 3'h7;
    #12;
    chk("rst_out_valid4", {28'd0, out_valid4}, 32'h0);
    chk("rst_out_data4", out_data4, 32'h0);
    chk("rst_drop_err3", {31'd0, drop_err3}, 32'h0);
    chk("rst_scan_ptr3", {30'd0, scan_ptr3}, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // Addressed, all consumers ready
    for (int c = 0; c < 4; c++) begin
      in_sel4 = 2'(c); in_data4 = 8'hA0 + 8'(c); in_valid4 = 1'b1;
      #1 chk("addr_in_ready", {31'd0, in_ready4}, 32'h1);
      tick();
      chk("addr_out_valid", {28'd0, out_valid4}, {28'd0, 4'b0001 << c});
      chk("addr_out_data", {24'd0, out_data4[c*8 +: 8]}, {24'd0, 8'hA0 + 8'(c)});
    end
    in_valid4 = 1'b0;
    tick();
    chk("addr_drained", {28'd0, out_valid4}, 32'h0);

    // Backpressure on ch2
    out_ready4 = 4'b1011;
    in_sel4 = 2'd2; in_data4 = 8'h55; in_valid4 = 1'b1;
    #1 chk("bp_first_ready", {31'd0, in_ready4}, 32'h1);
    tick();
    in_data4 = 8'h66;
    #1 chk("bp_stall_ready", {31'd0, in_ready4}, 32'h0);
    tick();
    chk("bp_hold_valid", {28'd0, out_valid4}, 32'h4);
    chk("bp_hold_data", {24'd0, out_data4[23:16]}, 32'h55);
    in_sel4 = 2'd1; in_data4 = 8'h77;
    #1 chk("bp_ch1_ready", {31'd0, in_ready4}, 32'h1);
    tick();
    chk("bp_ch1_valid", {28'd0, out_valid4}, 32'h6);
    chk("bp_ch1_data", {24'd0, out_data4[15:8]}, 32'h77);
    chk("bp_ch2_still", {24'd0, out_data4[23:16]}, 32'h55);
    in_sel4 = 2'd2; in_data4 = 8'h66;
    #1 chk("bp_ch2_blocked", {31'd0, in_ready4}, 32'h0);
    out_ready4 = 4'b1111;
    #1 chk("bp_ch2_unblocked", {31'd0, in_ready4}, 32'h1);
    tick();
    chk("bp_reload_valid", {28'd0, out_valid4}, 32'h4);
    chk("bp_reload_data", {24'd0, out_data4[23:16]}, 32'h66);
    in_valid4 = 1'b0;
    tick();
    chk("bp_drained", {28'd0, out_valid4}, 32'h0);

    // Broadcast with ch2 stalled
    mode4 = 2'd2; out_ready4 = 4'b1011;
    in_data4 = 8'hC3; in_valid4 = 1'b1;
    #1 chk("bc_ready_empty", {31'd0, in_ready4}, 32'h1);
    tick();
    chk("bc_valid_all", {28'd0, out_valid4}, 32'hF);
    chk("bc_data_c3", out_data4, 32'hC3C3C3C3);
    in_data4 = 8'hC4;
    #1 chk("bc_stall", {31'd0, in_ready4}, 32'h0);
    tick();
    chk("bc_only_ch2", {28'd0, out_valid4}, 32'h4);
    chk("bc_ch2_held", {24'd0, out_data4[23:16]}, 32'hC3);
    out_ready4 = 4'b1111;
    #1 chk("bc_release", {31'd0, in_ready4}, 32'h1);
    tick();
    chk("bc_valid_c4", {28'd0, out_valid4}, 32'hF);
    chk("bc_data_c4", out_data4, 32'hC4C4C4C4);
    in_valid4 = 1'b0;
    mode4 = 2'd3;
    #1 chk("rsvd_ready", {31'd0, in_ready4}, 32'h0);
    tick();

    // Scan on 3 channels; one settling edge so the mode change does not eat a beat
    mode3 = 2'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data3 = 8'(i + 1); in_valid3 = 1'b1;
      #1 chk("scan_ptr_pre", {30'd0, scan_ptr3}, {30'd0, scan_ch[i]});
      tick();
      chk("scan_valid", {29'd0, out_valid3}, {29'd0, 3'b001 << scan_ch[i]});
      chk("scan_data", {24'd0, out_data3[scan_ch[i]*8 +: 8]}, 32'(i + 1));
    end
    in_valid3 = 1'b0;
    chk("scan_ptr_end", {30'd0, scan_ptr3}, 32'h2);
    mode3 = 2'd0;
    tick();
    mode3 = 2'd1;
    tick();
    chk("scan_ptr_modechg", {30'd0, scan_ptr3}, 32'h0);

    // Invalid select on 3 channels
    mode3 = 2'd0;
    tick();
    in_sel3 = 2'd3; in_data3 = 8'hEE; in_valid3 = 1'b1;
    #1 chk("inv_ready", {31'd0, in_ready3}, 32'h1);
    tick();
    in_valid3 = 1'b0;
    chk("inv_drop_hi", {31'd0, drop_err3}, 32'h1);
    chk("inv_no_valid", {29'd0, out_valid3}, 32'h0);
    tick();
    chk("inv_drop_lo", {31'd0, drop_err3}, 32'h0);

    // Reset mid-stream: u4 scan leaves ch1 stalled and scan_ptr=2, u3 pulses drop_err
    mode4 = 2'd1; out_ready4 = 4'b1101;
    tick();
    in_data4 = 8'h90; in_valid4 = 1'b1;
    tick();
    in_data4 = 8'h91;
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    in_valid4 = 1'b0; in_valid3 = 1'b0;
    chk("pre_rst_valid", {28'd0, out_valid4}, 32'h2);
    chk("pre_rst_ptr", {30'd0, scan_ptr4}, 32'h2);
    chk("pre_rst_drop", {31'd0, drop_err3}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid4", {28'd0, out_valid4}, 32'h0);
    chk("arst_data4", out_data4, 32'h0);
    chk("arst_ptr4", {30'd0, scan_ptr4}, 32'h0);
    chk("arst_drop3", {31'd0, drop_err3}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
